// File: rtl/apb_txn_scheduler.sv
// apb_txn_scheduler: round-robin arbiter between queued AXI write and read
// requests, sequencing each grant as a single APB SETUP/ACCESS transfer with
// PREADY wait states and an optional ACCESS timeout, then returning a B or R
// response to the AXI side.
module apb_txn_scheduler #(
  parameter int unsigned ID_NUM  = 4,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                        ACLK_i,
  input  logic                        ARESET_i,
  input  logic                        wr_vld_i,
  output logic                        wr_rdy_o,
  input  logic [ID_NUM+ADDR_W+DATA_W-1:0] wr_payload_i,
  input  logic                        rd_vld_i,
  output logic                        rd_rdy_o,
  input  logic [ID_NUM+ADDR_W-1:0]    rd_payload_i,
  output logic                        PSEL_o,
  output logic                        PENABLE_o,
  output logic                        PWRITE_o,
  output logic [ADDR_W-1:0]           PADDR_o,
  output logic [DATA_W-1:0]           PWDATA_o,
  input  logic [DATA_W-1:0]           PRDATA_i,
  input  logic                        PREADY_i,
  input  logic                        PSLVERR_i,
  output logic                        bresp_vld_o,
  input  logic                        bresp_rdy_i,
  output logic [ID_NUM-1:0]           bresp_id_o,
  output logic                        bresp_err_o,
  output logic                        rresp_vld_o,
  input  logic                        rresp_rdy_i,
  output logic [ID_NUM-1:0]           rresp_id_o,
  output logic [DATA_W-1:0]           rresp_data_o,
  output logic                        rresp_err_o
);

  // Counter is at least one bit wide so TIMEOUT=0 still elaborates.
  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned WR_W  = ID_NUM + ADDR_W + DATA_W;
  localparam int unsigned RD_W  = ID_NUM + ADDR_W;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e              state_q, state_d;
  logic                prio_wr_q, prio_wr_d;
  logic [ID_NUM-1:0]   id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                write_q, write_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                bvld_q, bvld_d;
  logic                rvld_q, rvld_d;
  logic                grant_wr_c, grant_rd_c;

  // Round-robin grant, only offered while idle; ties go to the type with priority.
  always_comb begin
    grant_wr_c = 1'b0;
    grant_rd_c = 1'b0;
    if (state_q == IDLE) begin
      if (wr_vld_i && rd_vld_i) begin
        grant_wr_c = prio_wr_q;
        grant_rd_c = !prio_wr_q;
      end else begin
        grant_wr_c = wr_vld_i;
        grant_rd_c = rd_vld_i;
      end
    end
  end

  // Next-state and datapath for the transfer sequencer.
  always_comb begin
    state_d   = state_q;
    prio_wr_d = prio_wr_q;
    id_d      = id_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    write_d   = write_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_wr_c) begin
          id_d      = wr_payload_i[WR_W-1 -: ID_NUM];
          addr_d    = wr_payload_i[DATA_W +: ADDR_W];
          wdata_d   = wr_payload_i[DATA_W-1:0];
          write_d   = 1'b1;
          cnt_d     = '0;
          prio_wr_d = 1'b0;
          state_d   = SETUP;
        end else if (grant_rd_c) begin
          id_d      = rd_payload_i[RD_W-1 -: ID_NUM];
          addr_d    = rd_payload_i[ADDR_W-1:0];
          write_d   = 1'b0;
          cnt_d     = '0;
          prio_wr_d = 1'b1;
          state_d   = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (PREADY_i) begin
          err_d = PSLVERR_i;
          if (!write_q) rdata_d = PRDATA_i;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if ((TIMEOUT != 0) && (cnt_d == CNT_W'(TIMEOUT))) begin
            err_d = 1'b1;
            if (!write_q) rdata_d = '0;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if ((write_q && bresp_rdy_i) || (!write_q && rresp_rdy_i)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    psel_d    = (state_d == SETUP) || (state_d == ACCESS);
    penable_d = (state_d == ACCESS);
    bvld_d    = (state_d == RESP) && write_d;
    rvld_d    = (state_d == RESP) && !write_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      state_q   <= IDLE;
      prio_wr_q <= 1'b1;
      id_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      bvld_q    <= 1'b0;
      rvld_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_wr_q <= prio_wr_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      write_q   <= write_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      bvld_q    <= bvld_d;
      rvld_q    <= rvld_d;
    end
  end

  assign wr_rdy_o     = grant_wr_c;
  assign rd_rdy_o     = grant_rd_c;
  assign PSEL_o       = psel_q;
  assign PENABLE_o    = penable_q;
  assign PWRITE_o     = write_q;
  assign PADDR_o      = addr_q;
  assign PWDATA_o     = wdata_q;
  assign bresp_vld_o  = bvld_q;
  assign bresp_id_o   = id_q;
  assign bresp_err_o  = err_q;
  assign rresp_vld_o  = rvld_q;
  assign rresp_id_o   = id_q;
  assign rresp_data_o = rdata_q;
  assign rresp_err_o  = err_q;

endmodule

// File: doc/apb_txn_scheduler.md
Name: apb_txn_scheduler

Overview:
- Sits behind the AXI slave interface.
- Takes queued write requests (the W-side FIFO payload) and read requests, and arbitrates between them round-robin.
- Sequences each granted request as one APB transfer (SETUP/ACCESS), with PREADY wait states and a timeout.
- Returns per-transfer write and read responses to the AXI side for B/R channel generation.

Parameters:
- ID_NUM, 4: transaction ID width.
- ADDR_W, 12: APB address width.
- DATA_W, 32: data width.
- TIMEOUT, 16: maximum ACCESS cycles without PREADY before abort. 0 disables the timeout.

Ports:
- ACLK_i  in  1  clock; all logic on the rising edge.
- ARESET_i  in  1  reset; synchronous, active-high.
- wr_vld_i  in  1  write request valid.
- wr_rdy_o  out  1  write request accepted.
- wr_payload_i  in  ID_NUM+ADDR_W+DATA_W  write request, packed {id, addr, data} with id in the MSBs.
- rd_vld_i  in  1  read request valid.
- rd_rdy_o  out  1  read request accepted.
- rd_payload_i  in  ID_NUM+ADDR_W  read request, packed {id, addr}.
- PSEL_o  out  1  APB select.
- PENABLE_o  out  1  APB enable.
- PWRITE_o  out  1  APB direction.
- PADDR_o  out  ADDR_W  APB address.
- PWDATA_o  out  DATA_W  APB write data.
- PRDATA_i  in  DATA_W  APB read data.
- PREADY_i  in  1  APB ready.
- PSLVERR_i  in  1  APB slave error.
- bresp_vld_o  out  1  write response valid.
- bresp_rdy_i  in  1  write response ready.
- bresp_id_o  out  ID_NUM  write response ID.
- bresp_err_o  out  1  write response error (PSLVERR or timeout).
- rresp_vld_o  out  1  read response valid.
- rresp_rdy_i  in  1  read response ready.
- rresp_id_o  out  ID_NUM  read response ID.
- rresp_data_o  out  DATA_W  read response data.
- rresp_err_o  out  1  read response error (PSLVERR or timeout).

Behaviour:
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- Reset values:
  - All outputs are 0; all latched registers are 0.
  - The arbitration pointer is set so that write wins the first tie.
- IDLE:
  - If only one of wr_vld_i or rd_vld_i is high, that request is granted.
  - If both are high, the request type not granted last is granted, then the pointer flips. The pointer updates only on a grant.
  - wr_rdy_o and rd_rdy_o are combinational: high only in IDLE, and only for the granted request. At most one is high per cycle.
  - On the handshake: latch id, addr, data (write only) and direction, clear the wait counter, go to SETUP.
  - With no request, stay in IDLE.
- SETUP (exactly 1 cycle): PSEL_o=1, PENABLE_o=0, then go to ACCESS.
- ACCESS:
  - PSEL_o=1, PENABLE_o=1.
  - If PREADY_i=1: capture PRDATA_i (reads only) and PSLVERR_i into err, then go to RESP.
  - Otherwise increment the wait counter, width clog2(TIMEOUT+1).
  - If TIMEOUT!=0 and the counter reaches TIMEOUT with PREADY_i still 0: set err=1 and read data=0, drop PSEL_o/PENABLE_o next cycle, go to RESP.
  - If PREADY_i and the timeout coincide, PREADY wins and the normal completion path is taken.
- APB signal stability:
  - PADDR_o, PWRITE_o and PWDATA_o are registered and stable from SETUP through the last ACCESS cycle.
  - In IDLE and RESP they hold their last value; PSEL_o and PENABLE_o are 0.
- RESP:
  - Assert bresp_vld_o (write) or rresp_vld_o (read), never both.
  - ID, data and err are held stable until the matching rdy is sampled high, then go to IDLE.
  - Backpressure on responses stalls all new grants.
- Latency:
  - Request handshake at edge T; SETUP in cycle T+1; ACCESS in T+2.
  - With PREADY_i=1 in T+2, the response is valid in T+3.
  - Minimum turnaround is 4 cycles per transfer with an immediate response ready.
- Reset mid-operation: on the next edge with ARESET_i=1 the block returns to IDLE and PSEL_o/PENABLE_o fall. The in-flight transfer and any pending response are discarded.
- Back-to-back: a request held valid during RESP is not accepted until IDLE. There is never more than one APB transfer in flight.

Test Plan:
- Single write {id=3, addr=0x010, data=0xDEADBEEF}, PREADY=1 → SETUP then ACCESS with PADDR=0x010, PWRITE=1, PWDATA=0xDEADBEEF; bresp_vld_o 3 cycles after the handshake with id=3, err=0.
- Single read id=5, addr=0x020, PREADY low for 3 ACCESS cycles, PRDATA=0x12345678 → PSEL/PENABLE held for 4 ACCESS cycles; rresp id=5, data=0x12345678, err=0.
- wr_vld and rd_vld held high continuously with 4 requests each → grants alternate W,R,W,R…, with write first after reset; never two rdy outputs in one cycle.
- Read with PREADY stuck 0, TIMEOUT=16 → abort after 16 ACCESS cycles; rresp err=1, data=0; PSEL falls.
- Write with PSLVERR=1 and bresp_rdy low for 5 cycles → bresp_vld, id and err=1 stable for 6 cycles; no new grant during this time.
- ARESET_i asserted during ACCESS → next cycle IDLE, PSEL=0, no response emitted; the next request completes normally.
